coin_credit_ctrl: RTL and testbench

- Receiving end of the keypad coin interface: consumes one-cycle coin codes and accumulates credit in cents.
- Arbitrates vend requests against a price and returns change on a matching coin-code output.
- Change is issued greedily, largest coin first.
- Sits between the keypad interface and the vend/product-select logic.

---
 rtl/vm_coin_pkg.sv | 32 +++
 rtl/coin_change_gen.sv | 28 ++
 rtl/coin_credit_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_coin_credit_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vm_coin_pkg.sv
// Shared coin-interface definitions: code points, cent values, FSM states
// and the code-to-value decode used by the credit controller.
package vm_coin_pkg;

    localparam logic [2:0] COIN_IDLE    = 3'b111;
    localparam logic [2:0] COIN_DOLLAR  = 3'b101;
    localparam logic [2:0] COIN_QUARTER = 3'b110;
    localparam logic [2:0] COIN_DIME    = 3'b011;

    localparam int unsigned CENTS_DOLLAR  = 100;
    localparam int unsigned CENTS_QUARTER = 25;
    localparam int unsigned CENTS_DIME    = 10;

    // Wide enough for the largest coin value (100)
    localparam int VAL_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [VAL_W-1:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_DOLLAR:  return VAL_W'(CENTS_DOLLAR);
            COIN_QUARTER: return VAL_W'(CENTS_QUARTER);
            COIN_DIME:    return VAL_W'(CENTS_DIME);
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/coin_change_gen.sv
// Combinational greedy change selector: largest coin not exceeding credit,
// or COIN_IDLE with zero value when credit is below one dime.
module coin_change_gen
    import vm_coin_pkg::*;
#(
    parameter int CREDIT_W = 12
) (
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [2:0]          o_code,
    output logic [VAL_W-1:0]    o_value
);

    always_comb begin
        o_code  = COIN_IDLE;
        o_value = '0;
        if (i_credit >= CREDIT_W'(CENTS_DOLLAR)) begin
            o_code  = COIN_DOLLAR;
            o_value = VAL_W'(CENTS_DOLLAR);
        end else if (i_credit >= CREDIT_W'(CENTS_QUARTER)) begin
            o_code  = COIN_QUARTER;
            o_value = VAL_W'(CENTS_QUARTER);
        end else if (i_credit >= CREDIT_W'(CENTS_DIME)) begin
            o_code  = COIN_DIME;
            o_value = VAL_W'(CENTS_DIME);
        end
    end

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin credit accumulator with vend arbitration and greedy change return.
// Optional macro COIN_AUDIT_EN adds saturating accepted-coin counters.
module coin_credit_ctrl
    import vm_coin_pkg::*;
#(
    parameter int CREDIT_W   = 12,
    parameter int MAX_CREDIT = 500,
    parameter int GAP_CYC    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [2:0]          i_coin,
    input  logic [CREDIT_W-1:0] i_price,
    input  logic                i_vend_req,
    input  logic                i_cancel,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_vend_ok,
    output logic                o_vend_deny,
    output logic                o_reject,
    output logic [2:0]          o_change_coin,
    output logic                o_busy
`ifdef COIN_AUDIT_EN
    ,
    output logic [7:0]          o_cnt_dollar,
    output logic [7:0]          o_cnt_quarter,
    output logic [7:0]          o_cnt_dime
`endif
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_next;

    logic [CREDIT_W-1:0] r_credit;
    logic                r_vend_ok;
    logic                r_vend_deny;
    logic                r_reject;
    logic [2:0]          r_change;
    logic                r_busy;

    logic [CREDIT_W-1:0] w_credit_next;
    logic                w_vend_ok;
    logic                w_vend_deny;
    logic                w_reject;
    logic [2:0]          w_change;
    logic                w_accept;

    logic [2:0]          w_gen_code;
    logic [VAL_W-1:0]    w_gen_value;
    logic [VAL_W-1:0]    w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_fits;
    logic                w_coin_present;
    logic                w_afford;
    logic [CREDIT_W-1:0] w_remain;
    logic                w_credit_ge_dime;

    coin_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
        .i_credit (r_credit),
        .o_code   (w_gen_code),
        .o_value  (w_gen_value)
    );

    assign w_coin_val       = coin_value(i_coin);
    assign w_coin_present   = (i_coin != COIN_IDLE);
    assign w_sum            = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
    assign w_coin_fits      = (w_coin_val != '0) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign w_afford         = (r_credit >= i_price);
    // The subtraction is only selected once the compare has passed, so it never wraps
    assign w_remain         = w_afford ? (r_credit - i_price) : r_credit;
    assign w_credit_ge_dime = (r_credit >= CREDIT_W'(CENTS_DIME));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_next;
            r_gap   <= w_gap_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (i_vend_req) begin
                    if (w_afford && (w_remain >= CREDIT_W'(CENTS_DIME)))
                        w_state_next = ST_EMIT;
                end else if (i_cancel && w_credit_ge_dime) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_state_next = ST_GAP;
                w_gap_next   = GAP_W'(GAP_CYC);
            end
            ST_GAP: begin
                // Leave as the counter reaches zero so exactly GAP_CYC idle codes separate coins
                if (r_gap <= GAP_W'(1)) begin
                    w_gap_next   = '0;
                    w_state_next = w_credit_ge_dime ? ST_EMIT : ST_IDLE;
                end else begin
                    w_gap_next = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gap_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_credit_next = r_credit;
        w_vend_ok     = 1'b0;
        w_vend_deny   = 1'b0;
        w_reject      = 1'b0;
        w_change      = COIN_IDLE;
        w_accept      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_vend_req) begin
                    w_vend_ok     = w_afford;
                    w_vend_deny   = !w_afford;
                    w_credit_next = w_remain;
                    w_reject      = w_coin_present;
                end else if (i_cancel) begin
                    w_reject = w_coin_present;
                end else if (w_coin_present) begin
                    if (w_coin_fits) begin
                        w_accept      = 1'b1;
                        w_credit_next = w_sum[CREDIT_W-1:0];
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_EMIT, ST_GAP: begin
                w_vend_deny = i_vend_req;
                w_reject    = w_coin_present;
                if (r_state == ST_EMIT) begin
                    w_change      = w_gen_code;
                    w_credit_next = r_credit - CREDIT_W'(w_gen_value);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credit    <= '0;
            r_vend_ok   <= 1'b0;
            r_vend_deny <= 1'b0;
            r_reject    <= 1'b0;
            r_change    <= COIN_IDLE;
            r_busy      <= 1'b0;
        end else begin
            r_credit    <= w_credit_next;
            r_vend_ok   <= w_vend_ok;
            r_vend_deny <= w_vend_deny;
            r_reject    <= w_reject;
            r_change    <= w_change;
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    assign o_credit      = r_credit;
    assign o_vend_ok     = r_vend_ok;
    assign o_vend_deny   = r_vend_deny;
    assign o_reject      = r_reject;
    assign o_change_coin = r_change;
    assign o_busy        = r_busy;

`ifdef COIN_AUDIT_EN
    logic [7:0] r_cnt_dollar;
    logic [7:0] r_cnt_quarter;
    logic [7:0] r_cnt_dime;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_dollar  <= '0;
            r_cnt_quarter <= '0;
            r_cnt_dime    <= '0;
        end else if (w_accept) begin
            if (i_coin == COIN_DOLLAR && r_cnt_dollar != 8'hFF)
                r_cnt_dollar <= r_cnt_dollar + 8'd1;
            if (i_coin == COIN_QUARTER && r_cnt_quarter != 8'hFF)
                r_cnt_quarter <= r_cnt_quarter + 8'd1;
            if (i_coin == COIN_DIME && r_cnt_dime != 8'hFF)
                r_cnt_dime <= r_cnt_dime + 8'd1;
        end
    end

    assign o_cnt_dollar  = r_cnt_dollar;
    assign o_cnt_quarter = r_cnt_quarter;
    assign o_cnt_dime    = r_cnt_dime;
`endif

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Directed bench for coin_credit_ctrl: expected outputs are queued as each
// step is driven and popped by a checker one edge later.
module tb_coin_credit_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  coin = 3'b111;
    logic [11:0] price = '0;
    logic        vend = 1'b0;
    logic        cancel = 1'b0;
    logic [11:0] credit;
    logic        vend_ok, vend_deny, reject, busy;
    logic [2:0]  chg;
`ifdef COIN_AUDIT_EN
    logic [7:0]  cnt_d, cnt_q, cnt_m;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [11:0] credit;
        logic        ok;
        logic        deny;
        logic        rej;
        logic [2:0]  chg;
        logic        busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  ce;
    string ct;

    always #5 clk = ~clk;

    coin_credit_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_coin        (coin),
        .i_price       (price),
        .i_vend_req    (vend),
        .i_cancel      (cancel),
        .o_credit      (credit),
        .o_vend_ok     (vend_ok),
        .o_vend_deny   (vend_deny),
        .o_reject      (reject),
        .o_change_coin (chg),
        .o_busy        (busy)
`ifdef COIN_AUDIT_EN
        ,
        .o_cnt_dollar  (cnt_d),
        .o_cnt_quarter (cnt_q),
        .o_cnt_dime    (cnt_m)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: one queued expectation per driven step, checked after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            ct = tag_q.pop_front();
            chk({ct, ".credit"}, 32'(credit),    32'(ce.credit));
            chk({ct, ".ok"},     32'(vend_ok),   32'(ce.ok));
            chk({ct, ".deny"},   32'(vend_deny), 32'(ce.deny));
            chk({ct, ".rej"},    32'(reject),    32'(ce.rej));
            chk({ct, ".chg"},    32'(chg),       32'(ce.chg));
            chk({ct, ".busy"},   32'(busy),      32'(ce.busy));
        end
    end

    task automatic step(input string tag, input logic [2:0] c, input logic v,
                        input logic [11:0] p, input logic cn,
                        input logic [11:0] e_credit, input logic e_ok, input logic e_deny,
                        input logic e_rej, input logic [2:0] e_chg, input logic e_busy);
        exp_t e;
        @(negedge clk);
        coin = c; vend = v; price = p; cancel = cn;
        e.credit = e_credit; e.ok = e_ok; e.deny = e_deny;
        e.rej = e_rej; e.chg = e_chg; e.busy = e_busy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #2;
    endtask

    task automatic put(input string tag, input logic [2:0] c, input logic [11:0] e_credit, input logic e_rej);
        step(tag, c, 1'b0, 12'd0, 1'b0, e_credit, 1'b0, 1'b0, e_rej, 3'b111, 1'b0);
    endtask

    task automatic idle(input string tag, input logic [11:0] e_credit, input logic [2:0] e_chg, input logic e_busy);
        step(tag, 3'b111, 1'b0, 12'd0, 1'b0, e_credit, 1'b0, 1'b0, 1'b0, e_chg, e_busy);
    endtask

    // Four idle change codes after a coin; the last step shows whether another coin follows
    task automatic gap_wait(input string tag, input logic [11:0] e_credit, input logic last_busy);
        for (int i = 0; i < 3; i++) idle(tag, e_credit, 3'b111, 1'b1);
        idle(tag, e_credit, 3'b111, last_busy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; coin = 3'b111; vend = 1'b0; cancel = 1'b0; price = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".credit"}, 32'(credit),    32'd0);
        chk({tag, ".ok"},     32'(vend_ok),   32'd0);
        chk({tag, ".deny"},   32'(vend_deny), 32'd0);
        chk({tag, ".rej"},    32'(reject),    32'd0);
        chk({tag, ".chg"},    32'(chg),       32'b111);
        chk({tag, ".busy"},   32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Dollar + quarter, vend 115 -> one dime of change
        put("t1_dollar",  3'b101, 12'd100, 1'b0);
        put("t1_quarter", 3'b110, 12'd125, 1'b0);
        step("t1_vend", 3'b111, 1'b1, 12'd115, 1'b0, 12'd10, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1);
        idle("t1_dime", 12'd0, 3'b011, 1'b1);
        gap_wait("t1_gap", 12'd0, 1'b0);
        idle("t1_after", 12'd0, 3'b111, 1'b0);

        // Credit 135 cancelled -> dollar, quarter, dime; busy-time requests refused
        do_reset();
        put("t2_d", 3'b101, 12'd100, 1'b0);
        put("t2_q", 3'b110, 12'd125, 1'b0);
        put("t2_m", 3'b011, 12'd135, 1'b0);
        step("t2_cancel", 3'b111, 1'b0, 12'd0, 1'b1, 12'd135, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
        idle("t2_c1", 12'd35, 3'b101, 1'b1);
        step("t2_busycoin", 3'b101, 1'b0, 12'd0, 1'b0, 12'd35, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
        step("t2_busyvend", 3'b111, 1'b1, 12'd10, 1'b0, 12'd35, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1);
        step("t2_busycan", 3'b111, 1'b0, 12'd0, 1'b1, 12'd35, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
        idle("t2_g1end", 12'd35, 3'b111, 1'b1);
        idle("t2_c2", 12'd10, 3'b110, 1'b1);
        gap_wait("t2_g2", 12'd10, 1'b1);
        idle("t2_c3", 12'd0, 3'b011, 1'b1);
        gap_wait("t2_g3", 12'd0, 1'b0);

        // Five dollars fill to 500; further coins overflow or are invalid
        do_reset();
        put("t3_d1", 3'b101, 12'd100, 1'b0);
        put("t3_d2", 3'b101, 12'd200, 1'b0);
        put("t3_d3", 3'b101, 12'd300, 1'b0);
        put("t3_d4", 3'b101, 12'd400, 1'b0);
        put("t3_d5", 3'b101, 12'd500, 1'b0);
        put("t3_ovf", 3'b011, 12'd500, 1'b1);
        put("t3_bad", 3'b000, 12'd500, 1'b1);
        step("t3_vend500", 3'b111, 1'b1, 12'd500, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0);

        // Residue below a dime is kept, not dispensed
        do_reset();
        put("t4_q", 3'b110, 12'd25, 1'b0);
        put("t4_bad", 3'b001, 12'd25, 1'b1);
        step("t4_vend", 3'b111, 1'b1, 12'd20, 1'b0, 12'd5, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        idle("t4_hold", 12'd5, 3'b111, 1'b0);
        step("t4_cancel", 3'b111, 1'b0, 12'd0, 1'b1, 12'd5, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0);
        step("t4_cancoin", 3'b011, 1'b0, 12'd0, 1'b1, 12'd5, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);

        // Deny on short credit; vend beats a same-cycle coin
        do_reset();
        put("t5_q1", 3'b110, 12'd25, 1'b0);
        put("t5_q2", 3'b110, 12'd50, 1'b0);
        step("t5_deny", 3'b111, 1'b1, 12'd60, 1'b0, 12'd50, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0);
        step("t5_denycoin", 3'b110, 1'b1, 12'd60, 1'b0, 12'd50, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0);
        step("t5_okcoin", 3'b110, 1'b1, 12'd40, 1'b0, 12'd10, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1);
        idle("t5_dime", 12'd0, 3'b011, 1'b1);
        gap_wait("t5_gap", 12'd0, 1'b0);

        // Asynchronous reset during the gap after the first dollar
        do_reset();
        put("t6_d", 3'b101, 12'd100, 1'b0);
        put("t6_q", 3'b110, 12'd125, 1'b0);
        step("t6_cancel", 3'b111, 1'b0, 12'd0, 1'b1, 12'd125, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
        idle("t6_c1", 12'd25, 3'b101, 1'b1);
        idle("t6_gap", 12'd25, 3'b111, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) idle("t6_quiet", 12'd0, 3'b111, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
